// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: the fetch unit is master, the memory is slave.
// mem_req/mem_addr stay stable from request until the cycle mem_ack is seen.
interface if_fetch_unit_if;
   logic       mem_req;
   logic [9:0] mem_addr;
   logic       mem_ack;
   logic [9:0] mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: PC plus a direct-mapped 1-word/line I-cache, hits usable the same cycle as the PC.
// A miss drops cache_ready for at least 2 cycles; stall holds the PC only while running.
module if_fetch_unit #(
   parameter int LINES = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [9:0]      branch_target,
   input  logic            flush,
   if_fetch_unit_if.master mem,
   output logic [9:0]      instruction,
   output logic [9:0]      pc,
   output logic            cache_ready
);
   localparam int IDX = $clog2(LINES);
   localparam int TW  = 10 - IDX;

   typedef enum logic {RUN, MISS} state_t;
   state_t state;

   logic [LINES-1:0] valid;
   logic [TW-1:0]    tag_mem  [LINES];
   logic [9:0]       data_mem [LINES];
   logic             redir_pend;
   logic [9:0]       redir_tgt;

   logic [IDX-1:0]   idx;
   logic [IDX-1:0]   fill_idx;
   logic             hit;
   logic             fill;

   assign idx         = pc[IDX-1:0];
   assign hit         = valid[idx] && (tag_mem[idx] == pc[9:IDX]);
   assign cache_ready = (state == RUN) && hit;
   assign instruction = cache_ready ? data_mem[idx] : 10'd0;

   // The fill targets the latched request address, which equals pc while missing.
   assign fill_idx = mem.mem_addr[IDX-1:0];
   assign fill     = (state == MISS) && mem.mem_ack;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         pc           <= 10'd0;
         valid        <= '0;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= 10'd0;
         redir_pend   <= 1'b0;
         redir_tgt    <= 10'd0;
      end else begin
         case (state)
            RUN: begin
               // A redirect wins over starting a fill for the wrong-path address.
               if (branch_taken) begin
                  pc <= branch_target;
               end else if (!hit) begin
                  state        <= MISS;
                  mem.mem_req  <= 1'b1;
                  mem.mem_addr <= pc;
               end else if (!stall) begin
                  pc <= pc + 10'd1;
               end
            end
            MISS: begin
               if (mem.mem_ack) begin
                  valid[fill_idx] <= 1'b1;
                  state           <= RUN;
                  mem.mem_req     <= 1'b0;
                  redir_pend      <= 1'b0;
                  if (branch_taken)
                     pc <= branch_target;
                  else if (redir_pend)
                     pc <= redir_tgt;
               end else if (branch_taken) begin
                  redir_pend <= 1'b1;
                  redir_tgt  <= branch_target;
               end
            end
            default: state <= RUN;
         endcase
         // Last assignment wins, so a fill landing on a flush edge stays invalid.
         if (flush)
            valid <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && fill) begin
         tag_mem[fill_idx]  <= mem.mem_addr[9:IDX];
         data_mem[fill_idx] <= mem.mem_rdata;
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against an
// address-level cache model (line index -> cached address) with a memory of addr ^ 10'h155.
module tb_if_fetch_unit;
   localparam int LINES = 8;

   logic       clk = 1'b0;
   logic       reset, stall, branch_taken, flush;
   logic [9:0] branch_target;
   logic [9:0] instruction, pc;
   logic       cache_ready;

   if_fetch_unit_if mem ();

   if_fetch_unit #(.LINES(LINES)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .flush(flush), .mem(mem),
      .instruction(instruction), .pc(pc), .cache_ready(cache_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int ack_delay = 0;
   int req_age   = 0;

   int m_pc = 0;
   bit m_pend = 0;
   int m_req_addr = 0;
   bit m_redir = 0;
   int m_redir_tgt = 0;
   int m_line [int];

   function automatic logic [9:0] mem_word(input int a);
      return 10'(a) ^ 10'h155;
   endfunction

   function automatic bit m_hit(input int a);
      return m_line.exists(a % LINES) && (m_line[a % LINES] == a);
   endfunction

   function automatic bit m_ready();
      return !m_pend && m_hit(m_pc);
   endfunction

   // Drives one cycle (at the falling edge), advances the model, waits for the next falling edge.
   task automatic tick(input bit s, input bit b, input int t, input bit f,
                       input bit fa, input bit rst, input bit spur);
      bit a;
      a = (mem.mem_req === 1'b1) ? (req_age >= ack_delay) : spur;
      reset         = rst;
      stall         = s;
      branch_taken  = b;
      branch_target = 10'(t);
      flush         = f | (fa & a);
      mem.mem_ack   = a;
      mem.mem_rdata = a ? mem_word(int'(mem.mem_addr)) : 10'($urandom);
      if (mem.mem_req === 1'b1 && !a) req_age++;
      else req_age = 0;
      if (rst) begin
         m_pc = 0; m_pend = 0; m_req_addr = 0; m_redir = 0;
         m_line.delete();
      end else begin
         if (!m_pend) begin
            if (b) m_pc = t;
            else if (!m_hit(m_pc)) begin m_pend = 1; m_req_addr = m_pc; end
            else if (!s) m_pc = (m_pc + 1) % 1024;
         end else if (a) begin
            m_line[m_req_addr % LINES] = m_req_addr;
            m_pend = 0;
            if (b) m_pc = t;
            else if (m_redir) m_pc = m_redir_tgt;
            m_redir = 0;
         end else if (b) begin
            m_redir = 1; m_redir_tgt = t;
         end
         if (flush) m_line.delete();
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic jump(input int t);
      tick(0, 1, t, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      tick(0, 0, 0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 0, 1, 0);
      total++; if (pc !== 10'd0) begin bad++; $display("FAIL reset_pc got=%h want=000", pc); end
      total++; if (cache_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", cache_ready); end
      total++; if (instruction !== 10'd0) begin bad++; $display("FAIL reset_instr got=%h want=000", instruction); end
      total++; if (mem.mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", mem.mem_req); end
      total++; if (mem.mem_addr !== 10'd0) begin bad++; $display("FAIL reset_addr got=%h want=000", mem.mem_addr); end
   endtask

   task automatic test_cold_start();
      int n;
      ack_delay = 2;
      idle();
      total++; if (mem.mem_req !== 1'b1) begin bad++; $display("FAIL cold_req got=%b want=1", mem.mem_req); end
      total++; if (mem.mem_addr !== 10'd0) begin bad++; $display("FAIL cold_addr got=%h want=000", mem.mem_addr); end
      total++; if (cache_ready !== 1'b0) begin bad++; $display("FAIL cold_ready_low got=%b want=0", cache_ready); end
      n = 0;
      while (n < 10 && cache_ready !== 1'b1) begin idle(); n++; end
      total++; if (n !== 3) begin bad++; $display("FAIL cold_latency got=%0d want=3", n); end
      total++; if (instruction !== 10'h155) begin bad++; $display("FAIL cold_instr got=%h want=155", instruction); end
      total++; if (pc !== 10'd0) begin bad++; $display("FAIL cold_pc got=%h want=000", pc); end
      idle();
      total++; if (pc !== 10'd1) begin bad++; $display("FAIL cold_pc_next got=%h want=001", pc); end
   endtask

   task automatic test_warm_loop();
      int n;
      ack_delay = 0;
      n = 0;
      while (n < 60 && (m_pc != 8 || m_pend)) begin
         idle();
         n++;
         total++; if (pc !== 10'(m_pc)) begin bad++; $display("FAIL warm_fill_pc got=%h want=%h", pc, 10'(m_pc)); end
      end
      jump(0);
      for (int i = 0; i < 8; i++) begin
         total++; if (cache_ready !== 1'b1) begin bad++; $display("FAIL warm_ready[%0d] got=%b want=1", i, cache_ready); end
         total++; if (mem.mem_req !== 1'b0) begin bad++; $display("FAIL warm_req[%0d] got=%b want=0", i, mem.mem_req); end
         total++; if (pc !== 10'(i)) begin bad++; $display("FAIL warm_pc[%0d] got=%h want=%h", i, pc, 10'(i)); end
         idle();
      end
   endtask

   task automatic test_conflict();
      int n;
      ack_delay = 0;
      jump(3);
      total++; if (instruction !== mem_word(3) || cache_ready !== 1'b1) begin bad++; $display("FAIL conf_hit3 got=%b/%h want=1/%h", cache_ready, instruction, mem_word(3)); end
      jump(11);
      total++; if (cache_ready !== 1'b0) begin bad++; $display("FAIL conf_miss11 got=%b want=0", cache_ready); end
      n = 0;
      while (n < 10 && cache_ready !== 1'b1) begin idle(); n++; end
      total++; if (instruction !== mem_word(11) || pc !== 10'd11) begin bad++; $display("FAIL conf_fill11 got=%h@%h want=%h@00b", instruction, pc, mem_word(11)); end
      jump(3);
      total++; if (cache_ready !== 1'b0) begin bad++; $display("FAIL conf_evict3 got=%b want=0", cache_ready); end
      idle();
      total++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 10'd3) begin bad++; $display("FAIL conf_refetch3 got=%b/%h want=1/003", mem.mem_req, mem.mem_addr); end
      n = 0;
      while (n < 10 && cache_ready !== 1'b1) begin idle(); n++; end
      total++; if (instruction !== mem_word(3)) begin bad++; $display("FAIL conf_refill3 got=%h want=%h", instruction, mem_word(3)); end
   endtask

   task automatic test_branch_during_miss();
      int n;
      ack_delay = 4;
      jump(20);
      total++; if (cache_ready !== 1'b0) begin bad++; $display("FAIL bdm_miss got=%b want=0", cache_ready); end
      idle();
      tick(0, 1, 10'h200, 0, 0, 0, 0);
      n = 0;
      while (n < 12 && mem.mem_req === 1'b1) begin
         total++; if (pc !== 10'd20) begin bad++; $display("FAIL bdm_pc_held got=%h want=014", pc); end
         idle();
         n++;
      end
      total++; if (pc !== 10'h200) begin bad++; $display("FAIL bdm_redirect got=%h want=200", pc); end
      total++; if (cache_ready !== 1'b0) begin bad++; $display("FAIL bdm_ready got=%b want=0", cache_ready); end
      ack_delay = 0;
      idle();
      total++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 10'h200) begin bad++; $display("FAIL bdm_newmiss got=%b/%h want=1/200", mem.mem_req, mem.mem_addr); end
      n = 0;
      while (n < 10 && cache_ready !== 1'b1) begin idle(); n++; end
      total++; if (instruction !== mem_word(10'h200)) begin bad++; $display("FAIL bdm_fill200 got=%h want=%h", instruction, mem_word(10'h200)); end
      jump(20);
      total++; if (cache_ready !== 1'b1 || instruction !== mem_word(20)) begin bad++; $display("FAIL bdm_fill20 got=%b/%h want=1/%h", cache_ready, instruction, mem_word(20)); end
   endtask

   task automatic test_stall_wrap();
      int n;
      ack_delay = 0;
      jump(1023);
      n = 0;
      while (n < 10 && cache_ready !== 1'b1) begin idle(); n++; end
      total++; if (pc !== 10'd1023 || cache_ready !== 1'b1) begin bad++; $display("FAIL sw_start got=%h/%b want=3ff/1", pc, cache_ready); end
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 0, 0, 0, 0, 0);
         total++; if (pc !== 10'd1023) begin bad++; $display("FAIL sw_hold[%0d] got=%h want=3ff", i, pc); end
      end
      idle();
      total++; if (pc !== 10'd0) begin bad++; $display("FAIL sw_wrap got=%h want=000", pc); end
   endtask

   task automatic test_flush_reset();
      int n;
      ack_delay = 1;
      idle();
      total++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 10'd0) begin bad++; $display("FAIL fr_req got=%b/%h want=1/000", mem.mem_req, mem.mem_addr); end
      n = 0;
      while (n < 6 && mem.mem_req === 1'b1) begin tick(0, 0, 0, 0, 1, 0, 0); n++; end
      total++; if (cache_ready !== 1'b0) begin bad++; $display("FAIL fr_not_valid got=%b want=0", cache_ready); end
      idle();
      total++; if (mem.mem_req !== 1'b1 || mem.mem_addr !== 10'd0) begin bad++; $display("FAIL fr_remiss got=%b/%h want=1/000", mem.mem_req, mem.mem_addr); end
      ack_delay = 50;
      idle();
      tick(0, 0, 0, 0, 0, 1, 0);
      total++; if (mem.mem_req !== 1'b0 || pc !== 10'd0) begin bad++; $display("FAIL fr_reset got=%b/%h want=0/000", mem.mem_req, pc); end
      ack_delay = 0;
      tick(0, 0, 0, 0, 0, 0, 1);
      total++; if (cache_ready !== 1'b0 || mem.mem_req !== 1'b1) begin bad++; $display("FAIL fr_late_ack got=%b/%b want=0/1", cache_ready, mem.mem_req); end
      n = 0;
      while (n < 10 && cache_ready !== 1'b1) begin idle(); n++; end
      total++; if (instruction !== 10'h155) begin bad++; $display("FAIL fr_refill got=%h want=155", instruction); end
   endtask

   task automatic test_random();
      bit s, b, f, r, sp;
      int t;
      for (int i = 0; i < 600; i++) begin
         s  = ($urandom_range(0, 3) == 0);
         b  = ($urandom_range(0, 9) == 0);
         t  = ($urandom_range(0, 3) == 0) ? 1016 + $urandom_range(0, 7) : $urandom_range(0, 31);
         f  = ($urandom_range(0, 49) == 0);
         r  = ($urandom_range(0, 199) == 0);
         sp = $urandom_range(0, 1);
         if (mem.mem_req !== 1'b1) ack_delay = $urandom_range(0, 3);
         tick(s, b, t, f, 0, r, sp);
         total++; if (pc !== 10'(m_pc)) begin bad++; $display("FAIL rnd_pc[%0d] got=%h want=%h", i, pc, 10'(m_pc)); end
         total++; if (cache_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, cache_ready, m_ready()); end
         total++; if (instruction !== (m_ready() ? mem_word(m_pc) : 10'd0)) begin bad++; $display("FAIL rnd_instr[%0d] got=%h want=%h", i, instruction, m_ready() ? mem_word(m_pc) : 10'd0); end
         total++; if (mem.mem_req !== m_pend) begin bad++; $display("FAIL rnd_req[%0d] got=%b want=%b", i, mem.mem_req, m_pend); end
         total++; if (mem.mem_addr !== 10'(m_req_addr)) begin bad++; $display("FAIL rnd_addr[%0d] got=%h want=%h", i, mem.mem_addr, 10'(m_req_addr)); end
      end
   endtask

   initial begin
      test_reset();
      test_cold_start();
      test_warm_loop();
      test_conflict();
      test_branch_during_miss();
      test_stall_wrap();
      test_flush_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
